// File: rtl/atan2_mag_cordic.sv
// rtl/atan2_mag_cordic.sv - pipelined CORDIC vectoring unit: atan2 angle code and magnitude
// Define ATAN2_MAG_GAIN_COMP_EN to add a stage that removes the CORDIC gain from the magnitude.
module atan2_mag_cordic #(
  parameter int IN_BITW  = 12,
  parameter int OUT_BITW = 10,
  parameter int ITER     = 10,
  parameter int GUARD    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_BITW-1:0] in_y,
  input  logic signed [IN_BITW-1:0] in_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_BITW-1:0]       out_angle,
  output logic [IN_BITW+1:0]        out_mag
);

  // Fractional bits under the integer grid stop arithmetic-shift truncation from drifting x.
  localparam int  FRAC = 4;
  localparam int  W    = IN_BITW + 3 + FRAC;
  localparam int  ZW   = OUT_BITW + GUARD;
  localparam int  MW   = IN_BITW + 2;
  localparam int  PW   = W + 17;
  localparam real PI   = 3.14159265358979323846;
  localparam logic [PW-1:0] MAG_MAX = {{(PW-MW){1'b0}}, {MW{1'b1}}};

  function automatic logic [ZW-1:0] atan_code(input int i);
    real a;
    a = $atan(2.0 ** (-i)) * (2.0 ** ZW) / (2.0 * PI);
    return ZW'($rtoi(a + 0.5));
  endfunction

  logic                en;
  logic signed [W-1:0] x_d  [0:ITER];
  logic signed [W-1:0] x_q  [0:ITER];
  logic signed [W-1:0] y_d  [0:ITER-1];
  logic signed [W-1:0] y_q  [0:ITER-1];
  logic [ZW-1:0]       z_d  [0:ITER];
  logic [ZW-1:0]       z_q  [0:ITER];
  logic [2:0]          sp_d [0:ITER];
  logic [2:0]          sp_q [0:ITER];
  logic [ITER:0]       v_q;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic signed [W-1:0] xe;
  logic signed [W-1:0] ye;
  logic                neg;

  assign xe  = {{3{in_x[IN_BITW-1]}}, in_x, {FRAC{1'b0}}};
  assign ye  = {{3{in_y[IN_BITW-1]}}, in_y, {FRAC{1'b0}}};
  assign neg = in_x[IN_BITW-1];

  assign x_d[0] = neg ? -xe : xe;
  assign y_d[0] = neg ? -ye : ye;
  assign z_d[0] = neg ? {1'b1, {(ZW-1){1'b0}}} : '0;
  // Axis-aligned inputs (and 0,0) get an exact quadrant code that bypasses the accumulator.
  assign sp_d[0] = (in_y == '0) ? {1'b1, neg, 1'b0} :
                   (in_x == '0) ? {1'b1, in_y[IN_BITW-1], 1'b1} : 3'b000;

  for (genvar g = 0; g < ITER; g++) begin : g_stage
    localparam logic [ZW-1:0] A = atan_code(g);
    logic signed [W-1:0] ys;
    logic                dir;

    assign ys  = y_q[g] >>> g;
    assign dir = y_q[g][W-1];
    assign x_d[g+1]  = dir ? x_q[g] - ys : x_q[g] + ys;
    assign z_d[g+1]  = dir ? z_q[g] - A : z_q[g] + A;
    assign sp_d[g+1] = sp_q[g];

    if (g < ITER - 1) begin : g_y
      logic signed [W-1:0] xs;
      assign xs       = x_q[g] >>> g;
      assign y_d[g+1] = dir ? y_q[g] + xs : y_q[g] - xs;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= {v_q[ITER-1:0], in_valid};
    end
    if (en) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i]  <= x_d[i];
        z_q[i]  <= z_d[i];
        sp_q[i] <= sp_d[i];
      end
      for (int i = 0; i < ITER; i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

  logic [W-1:0]  xpos;
  logic          lv;
  logic [ZW-1:0] lz;
  logic [2:0]    lsp;
  logic [PW-1:0] mag_full;

  assign xpos = x_q[ITER][W-1] ? '0 : x_q[ITER];

`ifdef ATAN2_MAG_GAIN_COMP_EN
  function automatic int gain_k(input int n);
    real p;
    p = 1.0;
    for (int i = 0; i < n; i++) begin
      p = p / $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    return $rtoi(p * 65536.0 + 0.5);
  endfunction

  localparam int K = gain_k(ITER);

  logic [PW-1:0] p_q;
  logic [ZW-1:0] zg_q;
  logic [2:0]    spg_q;
  logic          vg_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vg_q <= 1'b0;
    end else if (en) begin
      vg_q <= v_q[ITER];
    end
    if (en) begin
      p_q   <= PW'(xpos) * PW'(K);
      zg_q  <= z_q[ITER];
      spg_q <= sp_q[ITER];
    end
  end

  assign lv       = vg_q;
  assign lz       = zg_q;
  assign lsp      = spg_q;
  assign mag_full = (p_q + (PW'(1) << (15 + FRAC))) >> (16 + FRAC);
`else
  assign lv       = v_q[ITER];
  assign lz       = z_q[ITER];
  assign lsp      = sp_q[ITER];
  assign mag_full = (PW'(xpos) + (PW'(1) << (FRAC - 1))) >> FRAC;
`endif

  logic [ZW-1:0]       zr;
  logic [OUT_BITW-1:0] ang_d;
  logic [MW-1:0]       mag_d;

  assign zr    = lz + ZW'(1 << (GUARD - 1));
  assign ang_d = lsp[2] ? {lsp[1:0], {(OUT_BITW-2){1'b0}}} : OUT_BITW'(zr >> GUARD);
  assign mag_d = (mag_full > MAG_MAX) ? {MW{1'b1}} : mag_full[MW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_angle <= '0;
      out_mag   <= '0;
    end else if (en) begin
      out_valid <= lv;
      out_angle <= ang_d;
      out_mag   <= mag_d;
    end
  end

endmodule
